// File: rtl/cl_tx_pattern_if.sv
// ---------------------------------------------------------------------------
// cl_tx_pattern_if
// Camera Link base/medium/full video bus as seen at the transmit side.
//   cl_fval            frame valid
//   cl_lval            line valid
//   cl_dval            data valid (mirrors cl_lval)
//   cl_port_a..j [7:0] tap data, A = tap 0 ... J = tap 9
// Modports: master drives the bus (pattern generator), slave receives it.
// ---------------------------------------------------------------------------
interface cl_tx_pattern_if;
   logic       cl_fval;
   logic       cl_lval;
   logic       cl_dval;
   logic [7:0] cl_port_a;
   logic [7:0] cl_port_b;
   logic [7:0] cl_port_c;
   logic [7:0] cl_port_d;
   logic [7:0] cl_port_e;
   logic [7:0] cl_port_f;
   logic [7:0] cl_port_g;
   logic [7:0] cl_port_h;
   logic [7:0] cl_port_i;
   logic [7:0] cl_port_j;

   modport master (
      output cl_fval, cl_lval, cl_dval,
      output cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e,
      output cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j
   );

   modport slave (
      input cl_fval, cl_lval, cl_dval,
      input cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e,
      input cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j
   );
endinterface

// File: rtl/cl_tx_pattern.sv
// ---------------------------------------------------------------------------
// cl_tx_pattern
// Camera Link transmit test pattern generator. Produces FVAL/LVAL/DVAL
// framing and a ten-tap pixel ramp: tap k = (line + 10*col + k) mod 256.
// Ports:
//   clk          pixel clock, rising edge
//   reset        asynchronous, active-high; clears state and all outputs
//   enable       level request for continuous frame generation
//   cl           Camera Link bus (cl_tx_pattern_if.master)
//   frame_count  completed frames, wraps 255 -> 0
//   busy         high whenever the generator is not idle
// Optional build macro:
//   CL_TX_FRAME_STAMP_EN  tap A carries frame_count at column 0 of each line
// ---------------------------------------------------------------------------
module cl_tx_pattern #(
   parameter int H_ACTIVE = 16,
   parameter int H_BLANK  = 4,
   parameter int V_ACTIVE = 8,
   parameter int FV_PRE   = 2,
   parameter int FV_POST  = 2,
   parameter int V_BLANK  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   cl_tx_pattern_if.master       cl,
   output logic [7:0]            frame_count,
   output logic                  busy
);

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAX_T  = max_of(max_of(max_of(H_ACTIVE, H_BLANK),
                                         max_of(FV_PRE, FV_POST)), V_BLANK);
   localparam int CNT_W  = (MAX_T > 1)    ? $clog2(MAX_T)    : 1;
   localparam int LINE_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int COL_W  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_FV_PRE, S_LINE, S_HBLANK, S_FV_POST, S_VBLANK
   } state_t;

   function automatic logic [7:0] ramp(input logic [LINE_W-1:0] line,
                                       input logic [COL_W-1:0]  col,
                                       input int                k);
      ramp = 8'(line) + 8'(col) * 8'd10 + 8'(k);
   endfunction

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [LINE_W-1:0] r_line, w_line_nxt;
   logic [COL_W-1:0]  r_col, w_col_nxt;
   logic [7:0]        r_frame_count, w_fc_nxt;
   logic              r_fval, r_lval, r_busy;
   logic [7:0]        r_tap [10];
   logic [7:0]        w_tap [10];
   logic              w_in_line, w_fval_nxt;

   // Next-state: one down-counter times every state, reloaded on entry.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt - CNT_W'(1);
      w_line_nxt  = r_line;
      w_col_nxt   = r_col;
      w_fc_nxt    = r_frame_count;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = r_cnt;
            if (enable) begin
               w_state_nxt = S_FV_PRE;
               w_cnt_nxt   = CNT_W'(FV_PRE - 1);
            end
         end
         S_FV_PRE: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_LINE;
               w_cnt_nxt   = CNT_W'(H_ACTIVE - 1);
               w_line_nxt  = '0;
               w_col_nxt   = '0;
            end
         end
         S_LINE: begin
            w_col_nxt = r_col + COL_W'(1);
            if (r_cnt == '0) begin
               w_col_nxt = '0;
               if (r_line == LINE_W'(V_ACTIVE - 1)) begin
                  w_state_nxt = S_FV_POST;
                  w_cnt_nxt   = CNT_W'(FV_POST - 1);
               end else begin
                  w_state_nxt = S_HBLANK;
                  w_cnt_nxt   = CNT_W'(H_BLANK - 1);
               end
            end
         end
         S_HBLANK: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_LINE;
               w_cnt_nxt   = CNT_W'(H_ACTIVE - 1);
               w_line_nxt  = r_line + LINE_W'(1);
               w_col_nxt   = '0;
            end
         end
         S_FV_POST: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_VBLANK;
               w_cnt_nxt   = CNT_W'(V_BLANK - 1);
               w_fc_nxt    = r_frame_count + 8'd1;
            end
         end
         S_VBLANK: begin
            if (r_cnt == '0) begin
               if (enable) begin
                  w_state_nxt = S_FV_PRE;
                  w_cnt_nxt   = CNT_W'(FV_PRE - 1);
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register on the same
   // edge as the state change.
   always_comb begin
      w_in_line  = (w_state_nxt == S_LINE);
      w_fval_nxt = (w_state_nxt == S_FV_PRE)  || (w_state_nxt == S_LINE) ||
                   (w_state_nxt == S_HBLANK)  || (w_state_nxt == S_FV_POST);
      for (int k = 0; k < 10; k++) begin
         w_tap[k] = w_in_line ? ramp(w_line_nxt, w_col_nxt, k) : 8'd0;
      end
`ifdef CL_TX_FRAME_STAMP_EN
      // frame_count cannot change inside LINE, so the next value is stable.
      if (w_in_line && (w_col_nxt == '0)) w_tap[0] = w_fc_nxt;
`endif
   end

   // Register stage: state, counters and every output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_line        <= '0;
         r_col         <= '0;
         r_frame_count <= '0;
         r_fval        <= 1'b0;
         r_lval        <= 1'b0;
         r_busy        <= 1'b0;
         for (int k = 0; k < 10; k++) r_tap[k] <= 8'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_line        <= w_line_nxt;
         r_col         <= w_col_nxt;
         r_frame_count <= w_fc_nxt;
         r_fval        <= w_fval_nxt;
         r_lval        <= w_in_line;
         r_busy        <= (w_state_nxt != S_IDLE);
         for (int k = 0; k < 10; k++) r_tap[k] <= w_tap[k];
      end
   end

   assign cl.cl_fval   = r_fval;
   assign cl.cl_lval   = r_lval;
   assign cl.cl_dval   = r_lval;
   assign cl.cl_port_a = r_tap[0];
   assign cl.cl_port_b = r_tap[1];
   assign cl.cl_port_c = r_tap[2];
   assign cl.cl_port_d = r_tap[3];
   assign cl.cl_port_e = r_tap[4];
   assign cl.cl_port_f = r_tap[5];
   assign cl.cl_port_g = r_tap[6];
   assign cl.cl_port_h = r_tap[7];
   assign cl.cl_port_i = r_tap[8];
   assign cl.cl_port_j = r_tap[9];
   assign frame_count  = r_frame_count;
   assign busy         = r_busy;

endmodule

// File: tb/tb_cl_tx_pattern.sv
// ---------------------------------------------------------------------------
// tb_cl_tx_pattern
// Three generators: default parameters, H_ACTIVE=32, and all-minimum
// parameters. Time t counts rising edges after the edge that samples
// enable=1 in IDLE (t=0 is that edge); outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_cl_tx_pattern;

`ifdef CL_TX_FRAME_STAMP_EN
   localparam bit STAMP = 1'b1;
`else
   localparam bit STAMP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst [3];
   logic       en  [3];
   logic [7:0] fc  [3];
   logic       bz  [3];
   logic       fv  [3];
   logic       lv  [3];
   logic       dv  [3];
   logic [7:0] pa  [3];
   logic [7:0] pj  [3];
   logic [7:0] tap0 [10];

   cl_tx_pattern_if cl0 ();
   cl_tx_pattern_if cl1 ();
   cl_tx_pattern_if cl2 ();

   cl_tx_pattern dut0 (
      .clk(clk), .reset(rst[0]), .enable(en[0]), .cl(cl0),
      .frame_count(fc[0]), .busy(bz[0]));

   cl_tx_pattern #(.H_ACTIVE(32)) dut1 (
      .clk(clk), .reset(rst[1]), .enable(en[1]), .cl(cl1),
      .frame_count(fc[1]), .busy(bz[1]));

   cl_tx_pattern #(.H_ACTIVE(1), .H_BLANK(1), .V_ACTIVE(1),
                   .FV_PRE(1), .FV_POST(1), .V_BLANK(1)) dut2 (
      .clk(clk), .reset(rst[2]), .enable(en[2]), .cl(cl2),
      .frame_count(fc[2]), .busy(bz[2]));

   assign fv[0] = cl0.cl_fval;  assign fv[1] = cl1.cl_fval;  assign fv[2] = cl2.cl_fval;
   assign lv[0] = cl0.cl_lval;  assign lv[1] = cl1.cl_lval;  assign lv[2] = cl2.cl_lval;
   assign dv[0] = cl0.cl_dval;  assign dv[1] = cl1.cl_dval;  assign dv[2] = cl2.cl_dval;
   assign pa[0] = cl0.cl_port_a; assign pa[1] = cl1.cl_port_a; assign pa[2] = cl2.cl_port_a;
   assign pj[0] = cl0.cl_port_j; assign pj[1] = cl1.cl_port_j; assign pj[2] = cl2.cl_port_j;

   assign tap0[0] = cl0.cl_port_a; assign tap0[1] = cl0.cl_port_b;
   assign tap0[2] = cl0.cl_port_c; assign tap0[3] = cl0.cl_port_d;
   assign tap0[4] = cl0.cl_port_e; assign tap0[5] = cl0.cl_port_f;
   assign tap0[6] = cl0.cl_port_g; assign tap0[7] = cl0.cl_port_h;
   assign tap0[8] = cl0.cl_port_i; assign tap0[9] = cl0.cl_port_j;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   function automatic int taps_or0();
      int r = 0;
      for (int k = 0; k < 10; k++) r = r | int'(tap0[k]);
      return r;
   endfunction

   // Reset generator d, release with enable=1; returns 1 ns after edge t=0.
   task automatic start(input int d);
      @(negedge clk);
      rst[d] = 1'b1;
      en[d]  = 1'b0;
      @(negedge clk);
      rst[d] = 1'b0;
      en[d]  = 1'b1;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int   dut;
      int   t;
      logic fval;
      logic lval;
      int   a;
      int   j;
      int   fc;
      logic busy;
   } vec_t;

   vec_t tbl [$];

   function automatic void add(input int d, input int t, input logic f, input logic l,
                               input int a, input int j, input int c, input logic b);
      vec_t v;
      v.dut = d; v.t = t; v.fval = f; v.lval = l;
      v.a = a; v.j = j; v.fc = c; v.busy = b;
      tbl.push_back(v);
   endfunction

   initial begin
      int cur_dut;
      int cur_t;
      int hi, lo, pulses, run, gap, bad_len, bad_gap, bad_dv, busy7, busy8;
      logic prev_l;

      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1;
         en[d]  = 1'b0;
      end

      // Default generator: frame at t=0..159, line L col c at t = 2 + 20L + c.
      add(0,   0, 1, 0,   0,   0, 0, 1);
      add(0,   1, 1, 0,   0,   0, 0, 1);
      add(0,   2, 1, 1,   0,   9, 0, 1);
      add(0,  17, 1, 1, 150, 159, 0, 1);
      add(0,  18, 1, 0,   0,   0, 0, 1);
      add(0,  21, 1, 0,   0,   0, 0, 1);
      add(0,  22, 1, 1, STAMP ? 0 : 1, 10, 0, 1);
      add(0,  67, 1, 1,  53,  62, 0, 1);
      add(0, 157, 1, 1, 157, 166, 0, 1);
      add(0, 159, 1, 0,   0,   0, 0, 1);
      add(0, 160, 0, 0,   0,   0, 1, 1);
      add(0, 167, 0, 0,   0,   0, 1, 1);
      add(0, 168, 1, 0,   0,   0, 1, 1);
      add(0, 170, 1, 1, STAMP ? 1 : 0, 9, 1, 1);
      add(0, 171, 1, 1,  10,  19, 1, 1);
      add(0, 495, 1, 0,   0,   0, 2, 1);
      add(0, 496, 0, 0,   0,   0, 3, 1);
      // H_ACTIVE=32: line L col c at t = 2 + 36L + c.
      add(1,  33, 1, 1,  54,  63, 0, 1);
      add(1,  34, 1, 0,   0,   0, 0, 1);
      add(1, 284, 1, 1,  51,  60, 0, 1);
      // All-minimum parameters: FVAL 3 clocks, LVAL on the middle one, period 4.
      add(2,   0, 1, 0,   0,   0, 0, 1);
      add(2,   1, 1, 1,   0,   9, 0, 1);
      add(2,   2, 1, 0,   0,   0, 0, 1);
      add(2,   3, 0, 0,   0,   0, 1, 1);
      add(2,   4, 1, 0,   0,   0, 1, 1);
      add(2,   5, 1, 1, STAMP ? 1 : 0, 9, 1, 1);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst fval", fv[0], 0);
      check("rst lval", lv[0], 0);
      check("rst dval", dv[0], 0);
      check("rst taps", taps_or0(), 0);
      check("rst frame_count", fc[0], 0);
      check("rst busy", bz[0], 0);

      // Table-driven vectors
      cur_dut = -1;
      cur_t   = 0;
      foreach (tbl[i]) begin
         if (tbl[i].dut != cur_dut) begin
            cur_dut = tbl[i].dut;
            start(cur_dut);
            cur_t = 0;
         end
         repeat (tbl[i].t - cur_t) @(posedge clk);
         #1;
         cur_t = tbl[i].t;
         check($sformatf("d%0d t%0d fval", cur_dut, cur_t), fv[cur_dut], tbl[i].fval);
         check($sformatf("d%0d t%0d lval", cur_dut, cur_t), lv[cur_dut], tbl[i].lval);
         check($sformatf("d%0d t%0d dval", cur_dut, cur_t), dv[cur_dut], tbl[i].lval);
         check($sformatf("d%0d t%0d port_a", cur_dut, cur_t), pa[cur_dut], tbl[i].a);
         check($sformatf("d%0d t%0d port_j", cur_dut, cur_t), pj[cur_dut], tbl[i].j);
         check($sformatf("d%0d t%0d frame_count", cur_dut, cur_t), fc[cur_dut], tbl[i].fc);
         check($sformatf("d%0d t%0d busy", cur_dut, cur_t), bz[cur_dut], tbl[i].busy);
      end

      // Frame shape with enable held high: 160 high, 8 LVAL x16, gaps 4, 8 low.
      start(0);
      hi = 0; pulses = 0; run = 0; gap = 0; bad_len = 0; bad_gap = 0; bad_dv = 0;
      prev_l = 1'b0;
      while (fv[0] && hi < 1000) begin
         if (dv[0] != lv[0]) bad_dv++;
         if (lv[0]) begin
            if (!prev_l) begin
               if (pulses > 0 && gap != 4) bad_gap++;
               pulses++;
               run = 0;
            end
            run++;
         end else begin
            if (prev_l) begin
               if (run != 16) bad_len++;
               gap = 0;
            end
            gap++;
         end
         prev_l = lv[0];
         hi++;
         @(posedge clk);
         #1;
      end
      check("shape fval high", hi, 160);
      check("shape lval pulses", pulses, 8);
      check("shape lval len errors", bad_len, 0);
      check("shape lval gap errors", bad_gap, 0);
      check("shape dval!=lval", bad_dv, 0);
      lo = 0; bad_dv = 0;
      while (!fv[0] && lo < 1000) begin
         if (lv[0] || dv[0]) bad_dv++;
         lo++;
         @(posedge clk);
         #1;
      end
      check("shape fval low", lo, 8);
      check("shape lval while fval low", bad_dv, 0);

      // Drop enable during line 2 (t=45): frame and VBLANK complete, then idle.
      hi = 0;
      while (fv[0] && hi < 1000) begin
         if (hi == 45) en[0] = 1'b0;
         hi++;
         @(posedge clk);
         #1;
      end
      check("drop fval high", hi, 160);
      lo = 0; busy7 = -1; busy8 = -1;
      while (!fv[0] && lo < 60) begin
         if (lo == 7) busy7 = bz[0];
         if (lo == 8) busy8 = bz[0];
         lo++;
         @(posedge clk);
         #1;
      end
      check("drop no further fval", lo, 60);
      check("drop busy in last vblank", busy7, 1);
      check("drop busy after vblank", busy8, 0);
      check("drop frame_count", fc[0], 2);

      // Reset for one clock in mid-line.
      en[0] = 1'b1;
      @(posedge clk);
      repeat (30) @(posedge clk);
      #1;
      check("mid lval before reset", lv[0], 1);
      #2;
      rst[0] = 1'b1;
      #1;
      check("arst fval", fv[0], 0);
      check("arst lval", lv[0], 0);
      check("arst dval", dv[0], 0);
      check("arst taps", taps_or0(), 0);
      check("arst frame_count", fc[0], 0);
      check("arst busy", bz[0], 0);
      @(posedge clk);
      #1;
      check("arst held busy", bz[0], 0);
      @(negedge clk);
      rst[0] = 1'b0;
      @(posedge clk);
      #1;
      check("restart fval", fv[0], 1);
      repeat (2) @(posedge clk);
      #1;
      check("restart lval", lv[0], 1);
      for (int k = 0; k < 10; k++)
         check($sformatf("restart tap%0d", k), tap0[k], k);
      check("restart frame_count", fc[0], 0);

      // 300 frames on the minimum generator: col 0 of each line, frame f.
      start(2);
      for (int f = 0; f < 300; f++) begin
         @(posedge clk);
         #1;
         check($sformatf("run f%0d port_a", f), pa[2], STAMP ? (f % 256) : 0);
         check($sformatf("run f%0d port_j", f), pj[2], 9);
         repeat (3) @(posedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
